// File: rtl/seq_shifter.sv
// Multi-cycle shifter/rotator: shifts by up to STEP positions per clock in SHIFT state,
// reporting the last bit moved out on carry and pulsing done when the result is ready.
module seq_shifter #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned STEP  = 1,
  localparam int unsigned AW   = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] data,
  input  logic [AW-1:0]    amount,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry
);

  localparam logic [2:0] OpShl = 3'b000;
  localparam logic [2:0] OpShr = 3'b001;
  localparam logic [2:0] OpSra = 3'b010;
  localparam logic [2:0] OpRol = 3'b011;
  localparam logic [2:0] OpRor = 3'b100;

  localparam logic [AW-1:0] StepA  = AW'(STEP);
  localparam logic [AW-1:0] WidthA = AW'(WIDTH);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             carry_q, carry_d;
  logic [AW-1:0]    remaining_q, remaining_d;
  logic [2:0]       op_q, op_d;

  logic [AW-1:0]    k;
  logic [WIDTH:0]   left_ext;   // {bit shifted out, shl result}
  logic [WIDTH:0]   right_ext;  // {shr result, bit shifted out}
  logic [WIDTH-1:0] sra_res;
  logic [WIDTH-1:0] rol_res;
  logic [WIDTH-1:0] ror_res;

  always_comb begin
    k         = (remaining_q > StepA) ? StepA : remaining_q;
    left_ext  = {1'b0, result_q} << k;
    right_ext = {result_q, 1'b0} >> k;
    sra_res   = WIDTH'($signed(result_q) >>> k);
    // k == 0 gives a shift by WIDTH on the wrapped half, which contributes nothing.
    rol_res   = (result_q << k) | (result_q >> (WidthA - k));
    ror_res   = (result_q >> k) | (result_q << (WidthA - k));
  end

  always_comb begin
    state_d     = state_q;
    result_d    = result_q;
    carry_d     = carry_q;
    remaining_d = remaining_q;
    op_d        = op_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          result_d    = data;
          // Illegal modes degrade to a zero-length pass-through.
          remaining_d = (op > OpRor) ? '0 : amount;
          op_d        = op;
          carry_d     = 1'b0;
          state_d     = StShift;
        end
      end
      StShift: begin
        remaining_d = remaining_q - k;
        case (op_q)
          OpShl: result_d = left_ext[WIDTH-1:0];
          OpShr: result_d = right_ext[WIDTH:1];
          OpSra: result_d = sra_res;
          OpRol: result_d = rol_res;
          OpRor: result_d = ror_res;
          default: result_d = result_q;
        endcase
        if (k != '0) begin
          case (op_q)
            OpShl, OpRol:        carry_d = left_ext[WIDTH];
            OpShr, OpSra, OpRor: carry_d = right_ext[0];
            default:             carry_d = carry_q;
          endcase
        end
        if (remaining_q <= StepA) state_d = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q     <= StIdle;
      result_q    <= '0;
      carry_q     <= 1'b0;
      remaining_q <= '0;
      op_q        <= '0;
    end else begin
      state_q     <= state_d;
      result_q    <= result_d;
      carry_q     <= carry_d;
      remaining_q <= remaining_d;
      op_q        <= op_d;
    end
  end

  assign busy   = (state_q != StIdle);
  assign done   = (state_q == StDone);
  assign result = result_q;
  assign carry  = carry_q;

endmodule

// File: tb/tb_seq_shifter.sv
// Scoreboard bench for seq_shifter: a STEP=1 and a STEP=4 instance, directed vectors with
// hand-computed results; monitors pop expectations on each done pulse.
module tb_seq_shifter;

  localparam logic [2:0] SHL = 3'b000;
  localparam logic [2:0] SHR = 3'b001;
  localparam logic [2:0] SRA = 3'b010;
  localparam logic [2:0] ROL = 3'b011;
  localparam logic [2:0] ROR = 3'b100;

  logic        clk = 1'b0;
  logic        clr;
  logic        start1, start4;
  logic [2:0]  op;
  logic [31:0] data;
  logic [5:0]  amount;
  logic        busy1, done1, carry1, busy4, done4, carry4;
  logic [31:0] result1, result4;

  typedef struct {
    string       nm;
    logic [31:0] res;
    logic        cy;
    int          lat;
  } exp_t;

  exp_t q1[$];
  exp_t q4[$];
  int   checks = 0;
  int   errors = 0;
  int   lat1 = 0;
  int   lat4 = 0;

  always #5 clk = ~clk;

  seq_shifter #(.WIDTH(32), .STEP(1)) u_dut1 (
    .clk(clk), .clr(clr), .start(start1), .op(op), .data(data), .amount(amount),
    .busy(busy1), .done(done1), .result(result1), .carry(carry1)
  );

  seq_shifter #(.WIDTH(32), .STEP(4)) u_dut4 (
    .clk(clk), .clr(clr), .start(start4), .op(op), .data(data), .amount(amount),
    .busy(busy4), .done(done4), .result(result4), .carry(carry4)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic push(input bit s4, input string nm, input logic [31:0] er, input logic ec,
                      input int el);
    exp_t e;
    e.nm = nm; e.res = er; e.cy = ec; e.lat = el;
    if (s4) q4.push_back(e);
    else q1.push_back(e);
  endtask

  // Monitors: lat counts SHIFT cycles (busy without done) since the last done.
  always @(negedge clk) begin
    if (!clr) lat1 = 0;
    else if (done1) begin
      if (q1.size() == 0) begin
        checks++; errors++;
        $display("FAIL step1 unexpected done: got done=1, expected no done");
      end else begin
        exp_t e;
        e = q1.pop_front();
        chk({e.nm, " result"}, result1, e.res);
        chk({e.nm, " carry"}, 32'(carry1), 32'(e.cy));
        chk({e.nm, " latency"}, 32'(lat1), 32'(e.lat));
      end
      lat1 = 0;
    end else if (busy1) lat1++;
  end

  always @(negedge clk) begin
    if (!clr) lat4 = 0;
    else if (done4) begin
      if (q4.size() == 0) begin
        checks++; errors++;
        $display("FAIL step4 unexpected done: got done=1, expected no done");
      end else begin
        exp_t e;
        e = q4.pop_front();
        chk({e.nm, " result"}, result4, e.res);
        chk({e.nm, " carry"}, 32'(carry4), 32'(e.cy));
        chk({e.nm, " latency"}, 32'(lat4), 32'(e.lat));
      end
      lat4 = 0;
    end else if (busy4) lat4++;
  end

  // Waits for done, then one more edge so the DUT is back in idle.
  task automatic wait_done(input bit s4);
    int n = 0;
    while (((s4 ? done4 : done1) !== 1'b1) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 200) begin
      checks++; errors++;
      $display("FAIL done timeout: got no done after %0d cycles, expected done", n);
    end
    @(posedge clk); #1;
  endtask

  task automatic issue(input bit s4, input string nm, input logic [2:0] o, input logic [31:0] d,
                       input logic [5:0] a, input logic [31:0] er, input logic ec, input int el);
    push(s4, nm, er, ec, el);
    op = o; data = d; amount = a;
    if (s4) start4 = 1'b1;
    else start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0; start4 = 1'b0;
    wait_done(s4);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    clr = 1'b0; start1 = 1'b0; start4 = 1'b0; op = '0; data = '0; amount = '0;
    #12;
    chk("reset busy1", 32'(busy1), 0);
    chk("reset done1", 32'(done1), 0);
    chk("reset result1", result1, 0);
    chk("reset carry1", 32'(carry1), 0);
    chk("reset busy4", 32'(busy4), 0);
    chk("reset result4", result4, 0);
    #1 clr = 1'b1;

    issue(0, "sra_neg4", SRA, 32'h8000_0000, 6'd4, 32'hF800_0000, 1'b0, 4);
    repeat (3) @(posedge clk);
    #1;
    chk("idle hold result", result1, 32'hF800_0000);
    chk("idle hold busy", 32'(busy1), 0);

    issue(0, "ror1", ROR, 32'h0000_0001, 6'd1, 32'h8000_0000, 1'b1, 1);
    issue(0, "shl32", SHL, 32'hFFFF_FFFF, 6'd32, 32'h0000_0000, 1'b1, 32);
    issue(0, "shl_amt0", SHL, 32'hDEAD_BEEF, 6'd0, 32'hDEAD_BEEF, 1'b0, 1);
    issue(0, "rol_amt0", ROL, 32'h1234_5678, 6'd0, 32'h1234_5678, 1'b0, 1);
    issue(0, "illegal_op", 3'b111, 32'hCAFE_F00D, 6'd5, 32'hCAFE_F00D, 1'b0, 1);
    issue(0, "rol4", ROL, 32'h9000_0001, 6'd4, 32'h0000_0019, 1'b1, 4);
    issue(0, "sra40", SRA, 32'h8000_0000, 6'd40, 32'hFFFF_FFFF, 1'b1, 40);
    issue(0, "sra33_pos", SRA, 32'h7FFF_FFFF, 6'd33, 32'h0000_0000, 1'b0, 33);
    issue(0, "ror33", ROR, 32'h0000_0001, 6'd33, 32'h8000_0000, 1'b1, 33);
    issue(0, "shr63", SHR, 32'hFFFF_FFFF, 6'd63, 32'h0000_0000, 1'b0, 63);

    issue(1, "s4_shr10", SHR, 32'h1234_5678, 6'd10, 32'h0004_8D15, 1'b1, 3);
    issue(1, "s4_rol8", ROL, 32'h1234_5678, 6'd8, 32'h3456_7812, 1'b0, 2);
    issue(1, "s4_sra6", SRA, 32'h8000_0000, 6'd6, 32'hFE00_0000, 1'b0, 2);
    issue(1, "s4_amt0", SHL, 32'hA5A5_A5A5, 6'd0, 32'hA5A5_A5A5, 1'b0, 1);

    // start pulsed with different operands while shifting must be ignored
    push(0, "busy_start", 32'h0000_000F, 1'b0, 4);
    op = SHR; data = 32'h0000_00F0; amount = 6'd4; start1 = 1'b1;
    @(posedge clk); #1 start1 = 1'b0;
    @(posedge clk); #1;
    op = SHL; data = 32'hFFFF_FFFF; amount = 6'd3; start1 = 1'b1;
    @(posedge clk); #1 start1 = 1'b0;
    wait_done(0);

    // start held high across done is taken again on the first idle edge
    push(0, "held_start_a", 32'h0000_0004, 1'b0, 2);
    push(0, "held_start_b", 32'h0000_0004, 1'b0, 2);
    op = SHL; data = 32'h0000_0001; amount = 6'd2; start1 = 1'b1;
    @(posedge clk); #1;
    wait_done(0);
    @(posedge clk); #1 start1 = 1'b0;
    wait_done(0);

    // asynchronous abort mid-shift, then restart on the first edge after release
    op = SHL; data = 32'h0000_FFFF; amount = 6'd20; start1 = 1'b1;
    @(posedge clk); #1 start1 = 1'b0;
    repeat (5) @(posedge clk);
    #2 clr = 1'b0;
    #1;
    chk("abort busy", 32'(busy1), 0);
    chk("abort done", 32'(done1), 0);
    chk("abort result", result1, 0);
    chk("abort carry", 32'(carry1), 0);
    push(0, "after_abort", 32'h8000_0000, 1'b1, 1);
    op = ROR; data = 32'h0000_0001; amount = 6'd1; start1 = 1'b1;
    #3 clr = 1'b1;
    @(posedge clk); #1 start1 = 1'b0;
    wait_done(0);

    repeat (5) @(posedge clk);
    #1;
    chk("step1 queue drained", 32'(q1.size()), 0);
    chk("step4 queue drained", 32'(q4.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
